// File: rtl/ttl_decode_bus_stage.sv
// Registered ID-stage helper: 74x138-style 3-to-8 decoder (active-low outputs)
// plus an N-source 32-bit wired-OR bus selector with a multi-select conflict flag.
module ttl_decode_bus_stage #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      dec_sel,
  input  logic            dec_g1,
  input  logic            dec_g2a_n,
  input  logic            dec_g2b_n,
  output logic [7:0]      dec_y_n,
  input  logic [N-1:0]    bus_sel_n,
  input  logic [32*N-1:0] bus_data,
  output logic [31:0]     bus_q,
  output logic            bus_conflict
);

  logic        dec_en_s;
  logic [7:0]  dec_next_s;
  logic [31:0] bus_next_s;
  logic        bus_seen_s;
  logic        bus_conflict_next_s;

  logic [7:0]  dec_y_n_r;
  logic [31:0] bus_q_r;
  logic        bus_conflict_r;

  assign dec_en_s = dec_g1 & ~dec_g2a_n & ~dec_g2b_n;

  // One-cold decoder: only the selected line is pulled low while enabled.
  always_comb begin
    dec_next_s = 8'hFF;
    if (dec_en_s) begin
      case (dec_sel)
        3'd0:    dec_next_s = 8'hFE;
        3'd1:    dec_next_s = 8'hFD;
        3'd2:    dec_next_s = 8'hFB;
        3'd3:    dec_next_s = 8'hF7;
        3'd4:    dec_next_s = 8'hEF;
        3'd5:    dec_next_s = 8'hDF;
        3'd6:    dec_next_s = 8'hBF;
        3'd7:    dec_next_s = 8'h7F;
        default: dec_next_s = 8'hFF;
      endcase
    end else begin
      dec_next_s = 8'hFF;
    end
  end

  // Wired-OR of all driving sources; a second active driver flags a conflict.
  always_comb begin
    bus_next_s          = 32'h0000_0000;
    bus_seen_s          = 1'b0;
    bus_conflict_next_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!bus_sel_n[k]) begin
        bus_next_s          = bus_next_s | bus_data[32*k +: 32];
        bus_conflict_next_s = bus_conflict_next_s | bus_seen_s;
        bus_seen_s          = 1'b1;
      end else begin
        bus_next_s = bus_next_s;
      end
    end
  end

  // Output registers; reset wins over any captured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_y_n_r      <= 8'hFF;
      bus_q_r        <= 32'h0000_0000;
      bus_conflict_r <= 1'b0;
    end else begin
      dec_y_n_r      <= dec_next_s;
      bus_q_r        <= bus_next_s;
      bus_conflict_r <= bus_conflict_next_s;
    end
  end

  assign dec_y_n      = dec_y_n_r;
  assign bus_q        = bus_q_r;
  assign bus_conflict = bus_conflict_r;

endmodule

// File: tb/tb_ttl_decode_bus_stage.sv
// Scoreboard bench for ttl_decode_bus_stage (N=3): stimulus pushes expected
// results from a behavioural model, an independent monitor pops and compares.
module tb_ttl_decode_bus_stage;

  localparam int N = 3;

  logic            clk;
  logic            rst;
  logic [2:0]      dec_sel;
  logic            dec_g1;
  logic            dec_g2a_n;
  logic            dec_g2b_n;
  logic [7:0]      dec_y_n;
  logic [N-1:0]    bus_sel_n;
  logic [32*N-1:0] bus_data;
  logic [31:0]     bus_q;
  logic            bus_conflict;

  typedef struct {
    logic [7:0]  dec;
    logic [31:0] bus;
    logic        conf;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  ttl_decode_bus_stage #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_sel      (dec_sel),
    .dec_g1       (dec_g1),
    .dec_g2a_n    (dec_g2a_n),
    .dec_g2b_n    (dec_g2b_n),
    .dec_y_n      (dec_y_n),
    .bus_sel_n    (bus_sel_n),
    .bus_data     (bus_data),
    .bus_q        (bus_q),
    .bus_conflict (bus_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic r, input logic [2:0] s, input logic g1,
                                 input logic g2a, input logic g2b, input logic [N-1:0] bsn,
                                 input logic [32*N-1:0] data);
    exp_t e;
    int   cnt;
    cnt   = 0;
    e.dec = 8'hFF;
    e.bus = 32'h0;
    e.conf = 1'b0;
    if (!r) begin
      if (g1 && !g2a && !g2b) e.dec = ~(8'h01 << s);
      for (int k = 0; k < N; k++) begin
        if (bsn[k] == 1'b0) begin
          e.bus = e.bus | data[32*k +: 32];
          cnt++;
        end
      end
      e.conf = (cnt >= 2);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [2:0] s, input logic g1, input logic g2a,
                       input logic g2b, input logic [N-1:0] bsn, input logic [32*N-1:0] data);
    @(negedge clk);
    rst       = r;
    dec_sel   = s;
    dec_g1    = g1;
    dec_g2a_n = g2a;
    dec_g2b_n = g2b;
    bus_sel_n = bsn;
    bus_data  = data;
    exp_q.push_back(model(r, s, g1, g2a, g2b, bsn, data));
  endtask

  // Monitor: the stage produces a result every cycle; compare just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("dec_y_n", {24'h0, dec_y_n}, {24'h0, e.dec});
      check("bus_q", bus_q, e.bus);
      check("bus_conflict", {31'h0, bus_conflict}, {31'h0, e.conf});
    end
  end

  logic [32*N-1:0] src;
  logic [2:0]      rs;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    dec_sel   = 3'd0;
    dec_g1    = 1'b0;
    dec_g2a_n = 1'b1;
    dec_g2b_n = 1'b1;
    bus_sel_n = '1;
    bus_data  = '0;
    src       = {32'h0000_0004, 32'hFFFF_F800, 32'h1111_0000};

    // Reset with decoder enabled and a bus source selected
    apply(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'b110, src);
    apply(1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'b110, src);

    // Decoder sweep
    for (int i = 0; i < 8; i++) apply(1'b0, i[2:0], 1'b1, 1'b0, 1'b0, 3'b111, src);

    // Decoder disables, including tied g2a_n/g2b_n
    apply(1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'b111, src);
    apply(1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 3'b111, src);
    apply(1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 3'b111, src);
    apply(1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 3'b111, src);
    apply(1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 3'b111, src);

    // Bus single / none / conflict
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b101, src);
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b011, src);
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b110, src);
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b111, src);
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b100, src);
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b000, src);

    // Back-to-back select changes with a one-cycle reset in the middle
    apply(1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 3'b110, src);
    apply(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 3'b101, src);
    apply(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'b011, src);
    apply(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 3'b001, src);
    apply(1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 3'b110, src);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rs = 3'($urandom_range(0, 7));
      apply(($urandom_range(0, 19) == 0), rs, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 3'($urandom), {$urandom, $urandom, $urandom});
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
